// File: rtl/chebyshev_sequencer_pkg.sv
// Shared types and defaults for the Chebyshev polynomial sequencer.
package chebyshev_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } seq_state_t;

    localparam int DEF_WORD_LENGTH  = 16;
    localparam int DEF_COEFF_LENGTH = 16;
    localparam int DEF_DEGREE       = 3;
    localparam int DEF_ITER_CYCLES  = 3;

    // Width needed to index 'entries' items; never narrower than one bit.
    function automatic int coeff_addr_width(input int entries);
        return (entries > 1) ? $clog2(entries) : 1;
    endfunction

endpackage

// File: rtl/chebyshev_coeff_regfile.sv
// Coefficient store: DEGREE+1 entries, one synchronous write port, one
// asynchronous read port. Cleared by reset.
module chebyshev_coeff_regfile
    import chebyshev_sequencer_pkg::*;
#(
    parameter int COEFF_LENGTH = DEF_COEFF_LENGTH,
    parameter int DEGREE       = DEF_DEGREE
) (
    input  logic                                      clock,
    input  logic                                      resetn,
    input  logic                                      we,
    input  logic [coeff_addr_width(DEGREE+1)-1:0]     waddr,
    input  logic [COEFF_LENGTH-1:0]                   wdata,
    input  logic [coeff_addr_width(DEGREE+1)-1:0]     raddr,
    output logic [COEFF_LENGTH-1:0]                   rdata
);

    logic [COEFF_LENGTH-1:0] mem [DEGREE+1];

    // Write port; the caller guarantees waddr is in range when we=1.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i <= DEGREE; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/chebyshev_sequencer.sv
// Horner-order sequencer: feeds x and coefficients (highest degree first)
// to an external multiply-add engine, then returns the engine result.
module chebyshev_sequencer
    import chebyshev_sequencer_pkg::*;
#(
    parameter int WORD_LENGTH  = DEF_WORD_LENGTH,
    parameter int COEFF_LENGTH = DEF_COEFF_LENGTH,
    parameter int DEGREE       = DEF_DEGREE,
    parameter int ITER_CYCLES  = DEF_ITER_CYCLES
) (
    input  logic                                  clock,
    input  logic                                  resetn,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [WORD_LENGTH-1:0]                in_x,
    input  logic                                  coeff_we,
    input  logic [coeff_addr_width(DEGREE+1)-1:0] coeff_addr,
    input  logic [COEFF_LENGTH-1:0]               coeff_wdata,
    output logic [WORD_LENGTH-1:0]                eng_data,
    output logic [COEFF_LENGTH-1:0]               eng_coeff,
    output logic                                  eng_clear,
    input  logic [WORD_LENGTH-1:0]                eng_result,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [WORD_LENGTH-1:0]                out_y,
    output logic                                  busy
);

    localparam int AW = coeff_addr_width(DEGREE+1);
    localparam int CW = coeff_addr_width(ITER_CYCLES);
    localparam logic [AW-1:0] K_TOP    = AW'(DEGREE);
    localparam logic [CW-1:0] CNT_LAST = CW'(ITER_CYCLES - 1);

    seq_state_t              state;
    logic [WORD_LENGTH-1:0]  x_reg;
    logic [AW-1:0]           step_k;
    logic [CW-1:0]           cycle_cnt;
    logic [COEFF_LENGTH-1:0] coeff_rd;
    logic                    coeff_wr_en;

    // Coefficients are only writable while idle, and only in range.
    assign coeff_wr_en = coeff_we && (state == IDLE) && (coeff_addr <= K_TOP);

    chebyshev_coeff_regfile #(
        .COEFF_LENGTH (COEFF_LENGTH),
        .DEGREE       (DEGREE)
    ) u_coeff_regfile (
        .clock  (clock),
        .resetn (resetn),
        .we     (coeff_wr_en),
        .waddr  (coeff_addr),
        .wdata  (coeff_wdata),
        .raddr  (step_k),
        .rdata  (coeff_rd)
    );

    // Sequencer FSM: accept sample, step k from DEGREE down to 0, drain, hold result.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            x_reg     <= '0;
            step_k    <= '0;
            cycle_cnt <= '0;
            out_y     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_reg     <= in_x;
                        step_k    <= K_TOP;
                        cycle_cnt <= '0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cycle_cnt == CNT_LAST) begin
                        cycle_cnt <= '0;
                        if (step_k == '0) begin
                            state <= DRAIN;
                        end else begin
                            step_k <= step_k - 1'b1;
                        end
                    end else begin
                        cycle_cnt <= cycle_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    out_y <= eng_result;
                    state <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == HOLD);
    assign eng_data  = (state == ISSUE) ? x_reg : '0;
    assign eng_coeff = (state == ISSUE) ? coeff_rd : '0;
    // Only the very first issue cycle has k at the top and the counter at zero.
    assign eng_clear = (state == ISSUE) && (step_k == K_TOP) && (cycle_cnt == '0);

endmodule

// File: tb/tb_chebyshev_sequencer.sv
// Self-checking bench for chebyshev_sequencer: directed scenarios followed
// by randomized traffic, compared each cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_chebyshev_sequencer;

    localparam int WL  = 16;
    localparam int CL  = 16;
    localparam int DEG = 3;
    localparam int IC  = 3;
    localparam int ISSUE_LEN = (DEG + 1) * IC;
    localparam int LAT = ISSUE_LEN + 1;

    logic          clock = 1'b0;
    logic          resetn;
    logic          in_valid;
    logic          in_ready;
    logic [WL-1:0] in_x;
    logic          coeff_we;
    logic [1:0]    coeff_addr;
    logic [CL-1:0] coeff_wdata;
    logic [WL-1:0] eng_data;
    logic [CL-1:0] eng_coeff;
    logic          eng_clear;
    logic [WL-1:0] eng_result;
    logic          out_valid;
    logic          out_ready;
    logic [WL-1:0] out_y;
    logic          busy;

    always #5 clock = ~clock;

    chebyshev_sequencer #(
        .WORD_LENGTH  (WL),
        .COEFF_LENGTH (CL),
        .DEGREE       (DEG),
        .ITER_CYCLES  (IC)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .coeff_we    (coeff_we),
        .coeff_addr  (coeff_addr),
        .coeff_wdata (coeff_wdata),
        .eng_data    (eng_data),
        .eng_coeff   (eng_coeff),
        .eng_clear   (eng_clear),
        .eng_result  (eng_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_y       (out_y),
        .busy        (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one evaluation in flight, tracked by edges since accept.
    logic [CL-1:0] mcoef [DEG+1];
    logic [CL-1:0] snap  [DEG+1];
    logic [WL-1:0] mx;
    logic [WL-1:0] exp_y;
    bit            active = 1'b0;
    int            n = 0;
    int            accepts = 0;
    int            handshakes = 0;

    initial begin
        for (int i = 0; i <= DEG; i++) mcoef[i] = '0;
        exp_y = '0;
        mx = '0;
    end

    // Compare DUT against the model mid-cycle, then advance the model using
    // the inputs that the next rising edge will sample.
    always @(negedge clock) begin
        if (!resetn) begin
            check_eq("rst_out_valid", 32'(out_valid), 0);
            check_eq("rst_busy", 32'(busy), 0);
            check_eq("rst_eng_clear", 32'(eng_clear), 0);
            check_eq("rst_eng_data", 32'(eng_data), 0);
            check_eq("rst_eng_coeff", 32'(eng_coeff), 0);
            check_eq("rst_out_y", 32'(out_y), 0);
            active = 1'b0;
            n = 0;
            for (int i = 0; i <= DEG; i++) mcoef[i] = '0;
        end else if (!active) begin
            check_eq("idle_in_ready", 32'(in_ready), 1);
            check_eq("idle_busy", 32'(busy), 0);
            check_eq("idle_out_valid", 32'(out_valid), 0);
            check_eq("idle_eng_clear", 32'(eng_clear), 0);
            check_eq("idle_eng_data", 32'(eng_data), 0);
            check_eq("idle_eng_coeff", 32'(eng_coeff), 0);
            if (coeff_we && (int'(coeff_addr) <= DEG)) mcoef[coeff_addr] = coeff_wdata;
            if (in_valid) begin
                active = 1'b1;
                n = 0;
                mx = in_x;
                for (int i = 0; i <= DEG; i++) snap[i] = mcoef[i];
                accepts++;
            end
        end else begin
            check_eq("busy_in_ready", 32'(in_ready), 0);
            check_eq("busy_busy", 32'(busy), 1);
            check_eq("out_valid", 32'(out_valid), 32'(n >= LAT));
            check_eq("eng_clear", 32'(eng_clear), 32'(n == 0));
            check_eq("eng_data", 32'(eng_data), (n < ISSUE_LEN) ? 32'(mx) : 0);
            check_eq("eng_coeff", 32'(eng_coeff), (n < ISSUE_LEN) ? 32'(snap[DEG - n / IC]) : 0);
            if (n >= LAT) check_eq("out_y", 32'(out_y), 32'(exp_y));
            if (n == LAT - 1) exp_y = eng_result;
            if (n >= LAT && out_ready) begin
                active = 1'b0;
                handshakes++;
            end else begin
                n++;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int cnt);
        for (int i = 0; i < cnt; i++) tick();
    endtask

    initial begin
        resetn      = 1'b0;
        in_valid    = 1'b0;
        in_x        = '0;
        coeff_we    = 1'b0;
        coeff_addr  = '0;
        coeff_wdata = '0;
        out_ready   = 1'b0;
        eng_result  = '0;
        ticks(2);
        resetn = 1'b1;
        tick();

        // Load coefficients 1..4 at addresses 0..3.
        for (int i = 0; i <= DEG; i++) begin
            coeff_we    = 1'b1;
            coeff_addr  = 2'(i);
            coeff_wdata = 16'(i + 1);
            tick();
        end
        coeff_we = 1'b0;

        // Evaluate x=0x0010 with a constant engine result; stall output for a while.
        eng_result = 16'h1234;
        in_x       = 16'h0010;
        in_valid   = 1'b1;
        tick();
        ticks(2);
        coeff_we    = 1'b1;
        coeff_addr  = 2'd2;
        coeff_wdata = 16'hFFFF;
        tick();
        coeff_we = 1'b0;
        ticks(LAT + 6);

        // Release output with in_valid still high: back-to-back evaluations.
        out_ready = 1'b1;
        ticks(2 * (LAT + 1) + 2);
        in_valid = 1'b0;
        ticks(LAT + 3);

        // Abort an evaluation with reset partway through.
        in_x     = 16'h0ABC;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        ticks(5);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();

        // Coefficients are now zero; run one evaluation to confirm.
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        ticks(LAT + 3);

        // Randomized traffic with occasional reset pulses.
        for (int c = 0; c < 3000; c++) begin
            in_valid    = ($urandom_range(0, 3) == 0);
            in_x        = 16'($urandom);
            coeff_we    = ($urandom_range(0, 2) == 0);
            coeff_addr  = 2'($urandom_range(0, 3));
            coeff_wdata = 16'($urandom);
            out_ready   = ($urandom_range(0, 2) != 0);
            eng_result  = 16'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                resetn = 1'b0;
                tick();
                resetn = 1'b1;
            end
            tick();
        end
        in_valid = 1'b0;
        coeff_we = 1'b0;
        ticks(2);

        check_eq("handshakes_seen", 32'(handshakes > 20), 1);
        check_eq("accepts_seen", 32'(accepts > 20), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/chebyshev_sequencer.md
CHEBYSHEV_SEQUENCER -- requirements
Module: chebyshev_sequencer

Interface
REQ-001 The block SHALL have parameter WORD_LENGTH, default 16, sample and result width.
REQ-002 The block SHALL have parameter COEFF_LENGTH, default 16, coefficient width.
REQ-003 The block SHALL have parameter DEGREE, default 3, polynomial degree; coefficient count = DEGREE+1.
REQ-004 The block SHALL have parameter ITER_CYCLES, default 3, cycles the engine needs per multiply-add step (engine input regs + mult + adder).
REQ-005 The block SHALL have port clock, input, 1, rising-edge clock.
REQ-006 The block SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have ports in_valid input 1, in_ready output 1, in_x input WORD_LENGTH: sample handshake.
REQ-008 The block SHALL have ports coeff_we input 1, coeff_addr input clog2(DEGREE+1), coeff_wdata input COEFF_LENGTH: coefficient write port.
REQ-009 The block SHALL have ports eng_data output WORD_LENGTH, eng_coeff output COEFF_LENGTH, eng_clear output 1: drive the computation engine data_in/coeff_in/accumulator clear.
REQ-010 The block SHALL have port eng_result, input, WORD_LENGTH, engine data_out.
REQ-011 The block SHALL have ports out_valid output 1, out_ready input 1, out_y output WORD_LENGTH: result handshake.
REQ-012 The block SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-013 FSM SHALL have states IDLE, ISSUE, DRAIN, HOLD.
REQ-014 In IDLE, in_ready SHALL be 1; in all other states 0 (one evaluation outstanding).
REQ-015 in_valid&in_ready at an edge SHALL latch in_x into x_reg, set step k=DEGREE, cycle counter=0, go to ISSUE.
REQ-016 eng_clear SHALL be 1 for exactly the first ISSUE cycle of each evaluation, 0 otherwise.
REQ-017 In ISSUE, eng_data SHALL equal x_reg and eng_coeff SHALL equal coeff[k] (Horner order, highest degree first).
REQ-018 Each step SHALL hold eng_coeff for exactly ITER_CYCLES cycles, then decrement k; after step k=0 completes, go to DRAIN.
REQ-019 DRAIN SHALL last exactly 1 cycle; at its end out_y SHALL capture eng_result and state go to HOLD.
REQ-020 out_valid SHALL be 1 only in HOLD, first asserting (DEGREE+1)*ITER_CYCLES+1 cycles after the accepting edge (13 at defaults).
REQ-021 out_y SHALL stay stable while out_valid=1 and out_ready=0; out_valid&out_ready at an edge SHALL return to IDLE.
REQ-022 in_valid SHALL NOT be accepted in the same cycle as the output handshake; earliest new accept is the cycle after.
REQ-023 Outside ISSUE, eng_data and eng_coeff SHALL be 0.
REQ-024 coeff_we=1 in IDLE with coeff_addr<=DEGREE SHALL write coeff[coeff_addr] at the edge; new value used by next evaluation.
REQ-025 coeff_we while busy=1, or coeff_addr>DEGREE, SHALL be ignored with no state change.
REQ-026 Simultaneous coeff_we and accepting in_valid in IDLE SHALL perform both; the evaluation uses the newly written value.
REQ-027 No arithmetic in this block; widths pass through unmodified; step and cycle counters SHALL NOT wrap within an evaluation.

Reset
REQ-028 resetn=0 SHALL asynchronously force state IDLE, all coeff entries 0, x_reg 0, out_y 0, counters 0.
REQ-029 During/after reset: in_ready=1 (after release), out_valid=0, busy=0, eng_clear=0, eng_data=0, eng_coeff=0.
REQ-030 Reset mid-evaluation SHALL abort it silently; no out_valid for the aborted sample.

Structure
REQ-031 Shared package SHALL hold the state enum, default WORD_LENGTH/COEFF_LENGTH/DEGREE/ITER_CYCLES and the coeff address width function.
REQ-032 Coefficient storage SHALL be sub-module chebyshev_coeff_regfile (DEGREE+1 entries, one write port, one async read port).

Verification
REQ-033 Write coeffs {0x0001,0x0002,0x0003,0x0004} to addr 0..3, accept x=0x0010 -> eng_coeff sequence 0x0004,0x0003,0x0002,0x0001, each 3 cycles, eng_clear single pulse.
REQ-034 Engine model returning 0x1234 -> out_valid exactly 13 cycles after accept, out_y=0x1234.
REQ-035 out_ready held 0 for 5 cycles -> out_valid and out_y stable; in_valid=1 meanwhile not accepted.
REQ-036 coeff_we addr 2 data 0xFFFF during ISSUE -> ignored; next evaluation still issues 0x0003 at step 2.
REQ-037 resetn pulsed low at cycle 6 of evaluation -> immediate IDLE, coeffs 0, no out_valid, in_ready=1 next cycle.
REQ-038 Back-to-back samples with out_ready=1 -> second accept on cycle after first output handshake, second result 13 cycles later.
